fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Instruction fetch buffer directly downstream of the program counter stage.
//  - Each cycle it captures {PC, PC+4, ROM instruction word} into a small FIFO.
//  - It presents the oldest entry to decode through a valid/ready handshake.
//  - in_ready drives the PC stage's hold select (PS=00) when the queue is full.
//  - flush discards all buffered (wrong-path) entries on a taken branch.
// PARAMETERS
//  DEPTH    4   entries; power of two, 2..16
//  AW       64  address width of pc / pc4
//  IW       32  instruction word width
// PORTS
//  clock      in   1          rising-edge clock
//  reset      in   1          asynchronous, active-high reset
//  flush      in   1          discard all entries (branch redirect)
//  in_valid   in   1          PC stage offers an entry
//  in_ready   out  1          queue accepts an entry this cycle
//  in_pc      in   AW         fetched address
//  in_pc4     in   AW         fetched address + 4
//  in_instr   in   IW         ROM word at in_pc
//  out_valid  out  1          head entry valid
//  out_ready  in   1          decode consumes head
//  out_pc     out  AW         head address
//  out_pc4    out  AW         head address + 4
//  out_instr  out  IW         head instruction
//  count      out  clog2(DEPTH)+1  current occupancy
// BEHAVIOUR
//  - Reset (async, active-high): wr_ptr=rd_ptr=0, count=0, out_valid=0, in_ready=1.
//    out_pc/out_pc4/out_instr read 0. Storage contents need not be cleared.
//  - push = in_valid & in_ready. pop = out_valid & out_ready.
//  - in_ready = (count != DEPTH). Combinational from registered count only.
//    There is no pass-through when full, even if out_ready=1.
//  - out_valid = (count != 0). out_* come from the head entry.
//    out_* are forced to 0 when empty.
//  - Latency: an entry pushed at edge N is visible on out_* after edge N.
//    There is no same-cycle bypass.
//  - Push and pop in the same cycle: count unchanged, both pointers advance.
//    Legal when full: pop frees a slot, but in_ready is already 0, so no push occurs.
//  - Pointers are clog2(DEPTH) bits and wrap modulo DEPTH. count saturates by
//    construction; it never exceeds DEPTH and never underflows.
//  - Sync flush: pointers and count return to 0 at the next edge.
//    flush outranks push and pop in the same cycle; both are ignored and the
//    offered entry is lost. The PC stage re-presents the target on the next cycle.
//  - Reset mid-operation drops all entries immediately. Handshakes resume the
//    cycle after reset deasserts.
//  - Inputs are sampled only on push. in_* may change freely while in_ready=0.
// CONFIGURATION
//  FETCH_QUEUE_PERF_EN defined adds output ports perf_stall[31:0] and perf_flush[31:0]:
//  - perf_stall increments each cycle with in_valid & ~in_ready.
//  - perf_flush increments each cycle flush=1.
//  - Both counters saturate at 32'hFFFFFFFF and reset to 0.
//  FETCH_QUEUE_PERF_EN undefined: the ports and counters are absent.
//  Functional behaviour is identical in both builds.
// STRUCTURE
//  fetch_pkg (shared with PC stage and decode):
//  - FQ_ENTRY_W = 2*AW+IW, field offsets for {pc, pc4, instr}.
//  - PS encodings PS_HOLD=2'b00, PS_INC=2'b01, PS_ABS=2'b10, PS_REL=2'b11.
//  Sub-module fetch_queue_ram:
//  - DEPTH x FQ_ENTRY_W register array, 1 write port, async read port.
//  - No reset on storage. Pointer/count/flush control stays in fetch_queue.
// TESTING
//  1. Reset then 3 pushes (pc=0,4,8; instr=A,B,C), out_ready=0
//     -> count=3, out_pc=0, out_instr=A.
//  2. Fill to DEPTH=4 with out_ready=0, hold in_valid=1
//     -> in_ready=0 and count stays 4. With FETCH_QUEUE_PERF_EN, perf_stall
//     counts those cycles.
//  3. Queue full, out_ready=1 for 1 cycle -> pop pc=0; count=3; in_ready=1 next
//     cycle; next push lands at wrapped wr_ptr=0.
//  4. Count=2, push and pop together for 8 cycles with pc incrementing by 4
//     -> count stays 2; out_pc lags in_pc by exactly 2 entries across wrap.
//  5. Count=3, flush=1 with in_valid=1 and out_ready=1 -> next cycle count=0,
//     out_valid=0, out_pc=0, the offered entry is absent, and perf_flush=1.
//  6. Assert reset asynchronously mid-stream (count=2) between edges
//     -> out_valid=0 and count=0 immediately; first push after release appears
//     one cycle later.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-path definitions used by the PC stage, fetch_queue and decode.
// Entry layout, most significant field first: {pc, pc4, instr}.
package fetch_pkg;

    localparam int FQ_DEPTH   = 4;
    localparam int FQ_AW      = 64;
    localparam int FQ_IW      = 32;
    localparam int FQ_ENTRY_W = 2*FQ_AW + FQ_IW;

    // Field offsets (LSB position) inside a default-width entry
    localparam int FQ_INSTR_LSB = 0;
    localparam int FQ_PC4_LSB   = FQ_IW;
    localparam int FQ_PC_LSB    = FQ_IW + FQ_AW;

    // PC stage next-PC select; PS_HOLD is chosen while the queue is full
    typedef enum logic [1:0] {
        PS_HOLD = 2'b00,
        PS_INC  = 2'b01,
        PS_ABS  = 2'b10,
        PS_REL  = 2'b11
    } ps_sel_e;

endpackage

// File: rtl/fetch_queue_ram.sv
// Entry storage for fetch_queue: DEPTH x W flops, one write port and one
// asynchronous read port. Contents are not reset; validity is tracked by
// the pointer/count logic in the parent.
module fetch_queue_ram #(
    parameter int DEPTH = 4,
    parameter int W     = 160,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          we,
    input  logic [PW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [PW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] r_mem [DEPTH];

    // Write the offered entry on push
    always_ff @(posedge clock) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch buffer between the PC stage and decode.
// Captures {pc, pc4, instr} on push, presents the oldest entry to decode,
// and drops everything on flush. in_ready low selects PS_HOLD in the PC stage.
// Optional build macro FETCH_QUEUE_PERF_EN adds saturating stall/flush counters.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int AW    = FQ_AW,
    parameter int IW    = FQ_IW
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [AW-1:0]              in_pc,
    input  logic [AW-1:0]              in_pc4,
    input  logic [IW-1:0]              in_instr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [AW-1:0]              out_pc,
    output logic [AW-1:0]              out_pc4,
    output logic [IW-1:0]              out_instr,
    output logic [$clog2(DEPTH):0]     count
`ifdef FETCH_QUEUE_PERF_EN
   ,output logic [31:0]                perf_stall,
    output logic [31:0]                perf_flush
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 2*AW + IW;
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic          w_in_ready;
    logic          w_out_valid;
    logic          w_push;
    logic          w_pop;
    logic [EW-1:0] w_wr_entry;
    logic [EW-1:0] w_rd_entry;

    // Handshake flags depend only on the registered occupancy
    assign w_in_ready  = (r_count != C_FULL);
    assign w_out_valid = (r_count != '0);
    assign w_push      = in_valid  & w_in_ready;
    assign w_pop       = w_out_valid & out_ready;
    assign w_wr_entry  = {in_pc, in_pc4, in_instr};

    fetch_queue_ram #(
        .DEPTH (DEPTH),
        .W     (EW),
        .PW    (PW)
    ) u_ram (
        .clock (clock),
        .we    (w_push & ~flush),
        .waddr (r_wr_ptr),
        .wdata (w_wr_entry),
        .raddr (r_rd_ptr),
        .rdata (w_rd_entry)
    );

    // Pointer and occupancy update; flush outranks push and pop
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Head entry fields, zeroed while the queue is empty
    always_comb begin
        out_pc    = '0;
        out_pc4   = '0;
        out_instr = '0;
        if (w_out_valid) begin
            out_pc    = w_rd_entry[EW-1 -: AW];
            out_pc4   = w_rd_entry[IW +: AW];
            out_instr = w_rd_entry[IW-1:0];
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign count     = r_count;

`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;

    // Saturating event counters: offered-but-refused cycles and flush cycles
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
        end else begin
            if (in_valid && !w_in_ready && (r_perf_stall != 32'hFFFF_FFFF)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (flush && (r_perf_flush != 32'hFFFF_FFFF)) begin
                r_perf_flush <= r_perf_flush + 32'd1;
            end
        end
    end

    assign perf_stall = r_perf_stall;
    assign perf_flush = r_perf_flush;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue. Stimulus drives inputs 1 time unit after each rising
// edge; a monitor on the falling edge holds a reference queue of accepted
// entries, compares the DUT against it and then advances it with the
// handshakes that the following rising edge will perform.
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_pc = '0;
    logic [63:0] in_pc4 = '0;
    logic [31:0] in_instr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_pc;
    logic [63:0] out_pc4;
    logic [31:0] out_instr;
    logic [2:0]  count;
`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] perf_stall;
    logic [31:0] perf_flush;
    int unsigned m_stall = 0;
    int unsigned m_flush = 0;
`endif

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] pc4;
        logic [31:0] instr;
    } entry_t;

    entry_t sb_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    fetch_queue u_dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_pc4    (in_pc4),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_pc4   (out_pc4),
        .out_instr (out_instr),
        .count     (count)
`ifdef FETCH_QUEUE_PERF_EN
       ,.perf_stall (perf_stall),
        .perf_flush (perf_flush)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus, applied just after the rising edge
    task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] ins,
                         input logic ordy, input logic fl);
        @(posedge clock);
        #1;
        in_valid  = v;
        in_pc     = pc;
        in_pc4    = pc + 64'd4;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
    endtask

    // Scoreboard monitor
    always @(negedge clock) begin
        if (reset) begin
            chk("rst_count", 64'(count), 64'd0);
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_in_ready", 64'(in_ready), 64'd1);
            sb_q.delete();
`ifdef FETCH_QUEUE_PERF_EN
            chk("rst_perf_stall", 64'(perf_stall), 64'd0);
            chk("rst_perf_flush", 64'(perf_flush), 64'd0);
            m_stall = 0;
            m_flush = 0;
`endif
        end else begin
            chk("mon_count", 64'(count), 64'(sb_q.size()));
            chk("mon_out_valid", 64'(out_valid), 64'(sb_q.size() != 0));
            chk("mon_in_ready", 64'(in_ready), 64'(sb_q.size() != DEPTH));
            if (sb_q.size() != 0) begin
                chk("mon_out_pc", out_pc, sb_q[0].pc);
                chk("mon_out_pc4", out_pc4, sb_q[0].pc4);
                chk("mon_out_instr", 64'(out_instr), 64'(sb_q[0].instr));
            end else begin
                chk("mon_empty_pc", out_pc, 64'd0);
                chk("mon_empty_instr", 64'(out_instr), 64'd0);
            end
`ifdef FETCH_QUEUE_PERF_EN
            chk("mon_perf_stall", 64'(perf_stall), 64'(m_stall));
            chk("mon_perf_flush", 64'(perf_flush), 64'(m_flush));
            if (in_valid && sb_q.size() == DEPTH) m_stall++;
            if (flush) m_flush++;
`endif
            if (flush) begin
                sb_q.delete();
            end else begin
                logic do_push;
                do_push = in_valid && (sb_q.size() != DEPTH);
                if (out_ready && sb_q.size() != 0) void'(sb_q.pop_front());
                if (do_push) sb_q.push_back('{pc: in_pc, pc4: in_pc4, instr: in_instr});
            end
        end
    end

    initial begin
        // Reset
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_out_pc", out_pc, 64'd0);

        // 1: three pushes, no consumption
        drive(1, 64'd0, 32'hAAAA_0001, 0, 0);
        drive(1, 64'd4, 32'hBBBB_0002, 0, 0);
        drive(1, 64'd8, 32'hCCCC_0003, 0, 0);
        drive(0, 64'd0, 32'h0, 0, 0);
        chk("t1_count", 64'(count), 64'd3);
        chk("t1_out_pc", out_pc, 64'd0);
        chk("t1_out_instr", 64'(out_instr), 64'hAAAA_0001);

        // 2: fill, then keep offering while full
        drive(1, 64'd12, 32'hDDDD_0004, 0, 0);
        drive(1, 64'd16, 32'hEEEE_0005, 0, 0);
        chk("t2_in_ready", 64'(in_ready), 64'd0);
        drive(1, 64'd16, 32'hEEEE_0005, 0, 0);
        drive(1, 64'd16, 32'hEEEE_0005, 0, 0);
        chk("t2_count_full", 64'(count), 64'd4);
        chk("t2_in_ready_hold", 64'(in_ready), 64'd0);
`ifdef FETCH_QUEUE_PERF_EN
        chk("t2_perf_stall", 64'(perf_stall), 64'd2);
`endif

        // 3: single pop while full, then push into the wrapped slot 0
        drive(0, 64'd0, 32'h0, 1, 0);
        chk("t3_out_pc_before_pop", out_pc, 64'd0);
        drive(1, 64'd16, 32'hEEEE_0005, 0, 0);
        chk("t3_count", 64'(count), 64'd3);
        chk("t3_in_ready", 64'(in_ready), 64'd1);
        chk("t3_head_pc", out_pc, 64'd4);
        drive(0, 64'd0, 32'h0, 0, 0);
        chk("t3_count_refill", 64'(count), 64'd4);

        // 4: drop to two, then 8 simultaneous push/pop cycles across the wrap
        drive(0, 64'd0, 32'h0, 1, 0);
        drive(0, 64'd0, 32'h0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            drive(1, 64'(20 + 4*i), 32'h1000_0000 + 32'(i), 1, 0);
            chk("t4_count", 64'(count), 64'd2);
            chk("t4_lag", out_pc, 64'(12 + 4*i));
        end
        drive(0, 64'd0, 32'h0, 0, 0);
        chk("t4_count_end", 64'(count), 64'd2);
        chk("t4_head_pc", out_pc, 64'd44);

        // 5: flush with a simultaneous push and pop
        drive(1, 64'd52, 32'h5555_0052, 0, 0);
        drive(1, 64'd56, 32'h5555_0056, 1, 1);
        chk("t5_count_pre", 64'(count), 64'd3);
        drive(0, 64'd0, 32'h0, 0, 0);
        chk("t5_count", 64'(count), 64'd0);
        chk("t5_out_valid", 64'(out_valid), 64'd0);
        chk("t5_out_pc", out_pc, 64'd0);
`ifdef FETCH_QUEUE_PERF_EN
        chk("t5_perf_flush", 64'(perf_flush), 64'd1);
`endif

        // 6: async reset mid-stream
        drive(1, 64'd60, 32'h6666_0060, 0, 0);
        drive(1, 64'd64, 32'h6666_0064, 0, 0);
        drive(0, 64'd0, 32'h0, 0, 0);
        chk("t6_count_pre", 64'(count), 64'd2);
        #2 reset = 1'b1;
        #1;
        chk("t6_async_out_valid", 64'(out_valid), 64'd0);
        chk("t6_async_count", 64'(count), 64'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        drive(1, 64'd68, 32'h7777_0068, 0, 0);
        chk("t6_no_bypass", 64'(out_valid), 64'd0);
        drive(0, 64'd0, 32'h0, 0, 0);
        chk("t6_out_valid", 64'(out_valid), 64'd1);
        chk("t6_out_pc", out_pc, 64'd68);
        chk("t6_count", 64'(count), 64'd1);

        // Drain and confirm the scoreboard empties
        drive(0, 64'd0, 32'h0, 1, 0);
        drive(0, 64'd0, 32'h0, 0, 0);
        chk("drain_count", 64'(count), 64'd0);
        @(posedge clock);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
